// File: rtl/dds_freq_cfg_ctrl.sv
// Purpose : sequences FTW words from the UART receiver into the DDS phase accumulator,
//           range-checking each word and applying it glitch-free at the accumulator wrap.
// Latency : rx_done -> new o_ftw in 3 cycles minimum (CHECK, WAIT_SYNC, APPLY); at most
//           SYNC_WAIT_MAX cycles spent waiting for i_dds_sync before a forced apply.
// Backpr. : none toward the receiver; a word arriving in CHECK/APPLY is parked in a one-deep
//           hold register (overwritten by later arrivals), a word arriving in WAIT_SYNC
//           replaces the pending word.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   i_rx_done         one-cycle pulse: i_rx_word is a complete 32-bit word
//   i_rx_word         assembled word, MSB byte first
//   i_rx_byte_num     receiver byte index, nonzero while a frame is in progress
//   i_dds_sync        one-cycle pulse at phase accumulator wrap
//   i_cfg_lock        (DDS_FREQ_CFG_LOCK_EN only) holds a checked word back from WAIT_SYNC
//   o_uart_rst        2-cycle reset request to the receiver after a stalled frame
//   o_ftw             active frequency tuning word
//   o_ftw_update      one-cycle pulse on the first cycle of a new o_ftw
//   o_busy            high whenever the FSM is not IDLE
//   o_err_range       one-cycle pulse on a word above FTW_MAX
//   o_rej_count       saturating count of rejected words
//
// Optional feature: define DDS_FREQ_CFG_LOCK_EN to add the i_cfg_lock input.

module dds_freq_cfg_ctrl #(
    parameter logic [31:0] FTW_DEFAULT    = 32'h0000_0000,
    parameter logic [31:0] FTW_MAX        = 32'h7FFF_FFFF,
    parameter int          SYNC_WAIT_MAX  = 1024,
    parameter int          TIMEOUT_CYCLES = 52100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rx_done,
    input  logic [31:0] i_rx_word,
    input  logic [1:0]  i_rx_byte_num,
    input  logic        i_dds_sync,
`ifdef DDS_FREQ_CFG_LOCK_EN
    input  logic        i_cfg_lock,
`endif
    output logic        o_uart_rst,
    output logic [31:0] o_ftw,
    output logic        o_ftw_update,
    output logic        o_busy,
    output logic        o_err_range,
    output logic [7:0]  o_rej_count
);

    localparam int SW = (SYNC_WAIT_MAX  > 1) ? $clog2(SYNC_WAIT_MAX)  : 1;
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_WAIT_MAX - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WAIT_SYNC = 2'd2,
        APPLY     = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [31:0]   r_pend;
    logic [31:0]   r_hold;
    logic          r_hold_valid;
    logic [SW-1:0] r_sync_cnt;
    logic [31:0]   r_ftw;
    logic          r_ftw_update;
    logic          r_busy;
    logic          r_err_range;
    logic [7:0]    r_rej_count;

    logic [WW-1:0] r_wd_cnt;
    logic [1:0]    r_byte_num_q;
    logic          r_uart_rst;
    logic          r_uart_ext;

    logic w_lock;
    logic w_illegal;
    logic w_same;
    logic w_pend_from_rx;
    logic w_pend_from_hold;
    logic w_hold_wr;
    logic w_hold_clr;
    logic w_reject;
    logic w_apply;
    logic w_sync_clr;
    logic w_sync_inc;

`ifdef DDS_FREQ_CFG_LOCK_EN
    assign w_lock = i_cfg_lock;
`else
    assign w_lock = 1'b0;
`endif

    assign w_illegal = (r_pend > FTW_MAX);
    assign w_same    = (r_pend == r_ftw);

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // ---------------- FSM next state / control strobes ----------------
    always_comb begin
        w_next_state     = r_state;
        w_pend_from_rx   = 1'b0;
        w_pend_from_hold = 1'b0;
        w_hold_wr        = 1'b0;
        w_hold_clr       = 1'b0;
        w_reject         = 1'b0;
        w_apply          = 1'b0;
        w_sync_clr       = 1'b0;
        w_sync_inc       = 1'b0;

        case (r_state)
            IDLE: begin
                if (r_hold_valid) begin
                    w_pend_from_hold = 1'b1;
                    w_hold_clr       = 1'b1;
                    w_next_state     = CHECK;
                    // A word landing while the hold drains re-fills it rather than being lost.
                    w_hold_wr        = i_rx_done;
                end else if (i_rx_done) begin
                    w_pend_from_rx = 1'b1;
                    w_next_state   = CHECK;
                end
            end
            CHECK: begin
                if (w_illegal) begin
                    w_reject     = 1'b1;
                    w_hold_wr    = i_rx_done;
                    w_next_state = IDLE;
                end else if (w_same) begin
                    w_hold_wr    = i_rx_done;
                    w_next_state = IDLE;
                end else if (w_lock) begin
                    // Locked: sit in CHECK; a fresh word replaces pend and gets re-checked.
                    w_pend_from_rx = i_rx_done;
                end else begin
                    w_sync_clr   = 1'b1;
                    w_hold_wr    = i_rx_done;
                    w_next_state = WAIT_SYNC;
                end
            end
            WAIT_SYNC: begin
                w_sync_inc = 1'b1;
                if (i_rx_done) begin
                    // Latest word wins; anything parked in hold is older, so drop it.
                    w_pend_from_rx = 1'b1;
                    w_hold_clr     = 1'b1;
                    w_next_state   = CHECK;
                end else if (w_lock) begin
                    w_next_state = CHECK;
                end else if (i_dds_sync || (r_sync_cnt == SYNC_LAST)) begin
                    w_apply      = 1'b1;
                    w_next_state = APPLY;
                end
            end
            APPLY: begin
                w_hold_wr    = i_rx_done;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ---------------- datapath / registered outputs ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend       <= 32'h0;
            r_hold       <= 32'h0;
            r_hold_valid <= 1'b0;
            r_sync_cnt   <= '0;
            r_ftw        <= FTW_DEFAULT;
            r_ftw_update <= 1'b0;
            r_busy       <= 1'b0;
            r_err_range  <= 1'b0;
            r_rej_count  <= 8'h00;
        end else begin
            if (w_pend_from_rx)        r_pend <= i_rx_word;
            else if (w_pend_from_hold) r_pend <= r_hold;

            // Write wins over clear so a same-cycle arrival stays parked.
            if (w_hold_wr) begin
                r_hold       <= i_rx_word;
                r_hold_valid <= 1'b1;
            end else if (w_hold_clr) begin
                r_hold_valid <= 1'b0;
            end

            if (w_sync_clr)      r_sync_cnt <= '0;
            else if (w_sync_inc) r_sync_cnt <= r_sync_cnt + 1'b1;

            // ftw and its update pulse move together on entry to APPLY.
            r_ftw_update <= w_apply;
            if (w_apply) r_ftw <= r_pend;

            r_busy      <= (w_next_state != IDLE);
            r_err_range <= w_reject;
            if (w_reject && (r_rej_count != 8'hFF)) r_rej_count <= r_rej_count + 8'd1;
        end
    end

    // ---------------- receiver stall watchdog ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt     <= '0;
            r_byte_num_q <= 2'd0;
            r_uart_rst   <= 1'b0;
            r_uart_ext   <= 1'b0;
        end else begin
            r_byte_num_q <= i_rx_byte_num;
            // r_uart_ext stretches the reset request to a second cycle.
            r_uart_rst   <= r_uart_ext;
            r_uart_ext   <= 1'b0;
            if (i_rx_done || (i_rx_byte_num == 2'd0) || (i_rx_byte_num != r_byte_num_q)) begin
                r_wd_cnt <= '0;
            end else if (r_wd_cnt == WD_LAST) begin
                r_wd_cnt   <= '0;
                r_uart_rst <= 1'b1;
                r_uart_ext <= 1'b1;
            end else begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
        end
    end

    assign o_uart_rst   = r_uart_rst;
    assign o_ftw        = r_ftw;
    assign o_ftw_update = r_ftw_update;
    assign o_busy       = r_busy;
    assign o_err_range  = r_err_range;
    assign o_rej_count  = r_rej_count;

endmodule
